// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared immediate-format codes and RV opcode constants for the
//               pipelined immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

   // Immediate format codes presented on imm_type
   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_Z    = 3'd5,
      IMM_NONE = 3'd7
   } imm_type_e;

   // Major opcodes (inst[6:0]) that carry an immediate
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/imm_form.sv
`default_nettype none
// ============================================================================
// Module      : imm_form
// Description : Combinational immediate classifier/former plus the PC-relative
//               target adder (pc + imm, wrapping at XLEN bits).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_form
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc,
   output logic [2:0]       imm_type,
   output logic [XLEN-1:0]  imm,
   output logic [XLEN-1:0]  target
);

   imm_type_e w_type;

   // Classify the immediate format from the major opcode
   always_comb begin
      w_type = IMM_NONE;
      case (inst[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_JALR: w_type = IMM_I;
         OPC_STORE:                     w_type = IMM_S;
         OPC_BRANCH:                    w_type = IMM_B;
         OPC_LUI, OPC_AUIPC:            w_type = IMM_U;
         OPC_JAL:                       w_type = IMM_J;
         // Only the CSR*I forms (funct3[2]=1) carry the 5-bit zimm
         OPC_SYSTEM:                    w_type = inst[14] ? IMM_Z : IMM_NONE;
         default:                       w_type = IMM_NONE;
      endcase
   end

   // Assemble and extend the immediate; size casts of signed operands sign-extend
   always_comb begin
      imm = '0;
      case (w_type)
         IMM_I:   imm = XLEN'($signed(inst[31:20]));
         IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         IMM_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
         IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         IMM_Z:   imm = XLEN'(inst[19:15]);
         default: imm = '0;
      endcase
   end

   assign imm_type = w_type;
   // Always computed; only meaningful for branches, JAL and AUIPC
   assign target   = pc + imm;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Decode-stage immediate generator with a DEPTH-entry circular
//               result queue, valid/ready on both sides, and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                inst,
   input  logic [XLEN-1:0]            pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            imm,
   output logic [2:0]                 imm_type,
   output logic [XLEN-1:0]            target,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Freshly formed result for the incoming instruction
   logic [2:0]      w_new_type;
   logic [XLEN-1:0] w_new_imm;
   logic [XLEN-1:0] w_new_target;

   // Queue storage (not reset)
   logic [XLEN-1:0] mem_imm_q    [DEPTH];
   logic [2:0]      mem_type_q   [DEPTH];
   logic [XLEN-1:0] mem_target_q [DEPTH];

   // Control state
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   // Registered head-of-queue outputs
   logic [XLEN-1:0] imm_q,    imm_d;
   logic [2:0]      type_q,   type_d;
   logic [XLEN-1:0] target_q, target_d;

   logic            w_push;
   logic            w_pop;

   imm_form #(
      .XLEN (XLEN)
   ) u_imm_form (
      .inst     (inst),
      .pc       (pc),
      .imm_type (w_new_type),
      .imm      (w_new_imm),
      .target   (w_new_target)
   );

   // Readiness depends only on registered occupancy, never on out_ready
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);

   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = out_valid && out_ready && !flush;

   // Next pointers/count and the next head value presented after the edge
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      imm_d    = imm_q;
      type_d   = type_q;
      target_d = target_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase

         // When non-empty after the edge, the head is either the entry being
         // written now (queue was empty past the pop) or an already stored one.
         // When empty, the last head value is held.
         if (count_d != '0) begin
            if (w_push && (rd_ptr_d == wr_ptr_q)) begin
               imm_d    = w_new_imm;
               type_d   = w_new_type;
               target_d = w_new_target;
            end else begin
               imm_d    = mem_imm_q[rd_ptr_d];
               type_d   = mem_type_q[rd_ptr_d];
               target_d = mem_target_q[rd_ptr_d];
            end
         end
      end
   end

   // Control and head registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         imm_q    <= '0;
         type_q   <= '0;
         target_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         imm_q    <= imm_d;
         type_q   <= type_d;
         target_q <= target_d;
      end
   end

   // Queue storage write on an accepted push
   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         mem_imm_q[wr_ptr_q]    <= w_new_imm;
         mem_type_q[wr_ptr_q]   <= w_new_type;
         mem_target_q[wr_ptr_q] <= w_new_target;
      end
   end

   assign imm      = imm_q;
   assign imm_type = type_q;
   assign target   = target_q;
   assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  ty;
      logic [31:0] tgt;
   } vec_t;

   localparam int NV = 11;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   // XLEN=32 instance signals
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inst = '0;
   logic [31:0] pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] imm;
   logic [2:0]  imm_type;
   logic [31:0] target;
   logic [1:0]  count;

   // XLEN=64 instance signals
   logic        f64 = 1'b0;
   logic        iv64 = 1'b0;
   logic        ir64;
   logic [31:0] inst64 = '0;
   logic [63:0] pc64 = '0;
   logic        ov64;
   logic        or64 = 1'b0;
   logic [63:0] imm64;
   logic [2:0]  ty64;
   logic [63:0] tgt64;
   logic [1:0]  cnt64;

   int total = 0;
   int bad = 0;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .inst(inst), .pc(pc), .out_valid(out_valid),
      .out_ready(out_ready), .imm(imm), .imm_type(imm_type),
      .target(target), .count(count)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .flush(f64), .in_valid(iv64),
      .in_ready(ir64), .inst(inst64), .pc(pc64), .out_valid(ov64),
      .out_ready(or64), .imm(imm64), .imm_type(ty64),
      .target(tgt64), .count(cnt64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push64(input logic [31:0] i, input logic [63:0] p,
                         input logic [63:0] ei, input logic [2:0] et, input logic [63:0] eg);
      iv64   = 1'b1;
      or64   = 1'b1;
      inst64 = i;
      pc64   = p;
      @(negedge clk);
      chk("x64_valid", 64'(ov64), 64'd1);
      chk("x64_imm", imm64, ei);
      chk("x64_type", 64'(ty64), 64'(et));
      chk("x64_target", tgt64, eg);
   endtask

   initial begin
      //            inst          pc            imm           type  target
      vecs[0]  = '{32'hFFF00093, 32'h00000000, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF}; // addi -1
      vecs[1]  = '{32'hFE000EE3, 32'h00000100, 32'hFFFFFFFC, 3'd2, 32'h000000FC}; // branch -4
      vecs[2]  = '{32'h300FD073, 32'h00000200, 32'h0000001F, 3'd5, 32'h0000021F}; // csrrwi
      vecs[3]  = '{32'hFE20AC23, 32'h00000040, 32'hFFFFFFF8, 3'd1, 32'h00000038}; // sw -8
      vecs[4]  = '{32'h123450B7, 32'h00000000, 32'h12345000, 3'd3, 32'h12345000}; // lui
      vecs[5]  = '{32'h80000097, 32'h00001000, 32'h80000000, 3'd3, 32'h80001000}; // auipc
      vecs[6]  = '{32'h008000EF, 32'h00000300, 32'h00000008, 3'd4, 32'h00000308}; // jal +8
      vecs[7]  = '{32'hFFDFF06F, 32'h00000010, 32'hFFFFFFFC, 3'd4, 32'h0000000C}; // jal -4
      vecs[8]  = '{32'h00000073, 32'h00000044, 32'h00000000, 3'd7, 32'h00000044}; // ecall
      vecs[9]  = '{32'h30009073, 32'h00000008, 32'h00000000, 3'd7, 32'h00000008}; // csrrw
      vecs[10] = '{32'h7FF12083, 32'h00000000, 32'h000007FF, 3'd0, 32'h000007FF}; // lw 0x7ff

      // Reset held for two cycles
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_imm", 64'(imm), 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Back-to-back table: each entry pushed while the previous one pops
      for (int i = 0; i < NV; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         inst      = vecs[i].inst;
         pc        = vecs[i].pc;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_imm", i), 64'(imm), 64'(vecs[i].imm));
         chk($sformatf("vec%0d_type", i), 64'(imm_type), 64'(vecs[i].ty));
         chk($sformatf("vec%0d_target", i), 64'(target), 64'(vecs[i].tgt));
         chk($sformatf("vec%0d_count", i), 64'(count), 64'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("empty_hold_imm", 64'(imm), 64'h7FF);

      // Backpressure: three offered, two accepted, drained in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 32'h00100093; pc = 32'h0;
      @(negedge clk);
      chk("bp_count1", 64'(count), 64'd1);
      inst = 32'h00200093;
      @(negedge clk);
      chk("bp_count2", 64'(count), 64'd2);
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      inst = 32'h00300093;
      @(negedge clk);
      chk("bp_count_stuck", 64'(count), 64'd2);
      chk("bp_ready_stuck", 64'(in_ready), 64'd0);
      chk("bp_head_a", 64'(imm), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_pop1_count", 64'(count), 64'd1);
      chk("bp_pop1_imm", 64'(imm), 64'd2);
      chk("bp_pop1_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("bp_pop2_count", 64'(count), 64'd0);
      chk("bp_pop2_valid", 64'(out_valid), 64'd0);
      chk("bp_pop2_hold", 64'(imm), 64'd2);

      // Flush with a full queue and a simultaneous push
      out_ready = 1'b0;
      in_valid  = 1'b1;
      inst      = 32'h00100093;
      @(negedge clk);
      inst = 32'h00200093;
      @(negedge clk);
      chk("fl_pre_count", 64'(count), 64'd2);
      flush = 1'b1;
      inst  = 32'h00400093;
      @(negedge clk);
      chk("fl_count", 64'(count), 64'd0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("fl_no_enq_count", 64'(count), 64'd0);
      chk("fl_no_enq_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of traffic clears state and head outputs
      in_valid = 1'b1;
      inst     = 32'hFE000EE3; pc = 32'h100;
      @(negedge clk);
      chk("mr_pre_count", 64'(count), 64'd1);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(negedge clk);
      chk("mr_count", 64'(count), 64'd0);
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_imm", 64'(imm), 64'd0);
      chk("mr_type", 64'(imm_type), 64'd0);
      chk("mr_target", 64'(target), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // XLEN=64: sign extension from bit 31 and 64-bit target wrap
      push64(32'h800000B7, 64'h0,
             64'hFFFFFFFF80000000, 3'd3, 64'hFFFFFFFF80000000);
      push64(32'hFFF00093, 64'h5,
             64'hFFFFFFFFFFFFFFFF, 3'd0, 64'h4);
      push64(32'hFE000EE3, 64'h0000000100000000,
             64'hFFFFFFFFFFFFFFFC, 3'd2, 64'h00000000FFFFFFFC);
      push64(32'h80000097, 64'h0000000100000000,
             64'hFFFFFFFF80000000, 3'd3, 64'h0000000080000000);
      iv64 = 1'b0;
      @(negedge clk);
      chk("x64_drain_count", 64'(cnt64), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts instructions with a PC over a valid/ready handshake, classifies the immediate format, forms the XLEN-wide immediate and the PC-relative target `pc + imm`, and buffers results in a DEPTH-entry queue so fetch and execute can stall independently. It supersedes the purely combinational RV32I immediate generator: XLEN is parametrised, CSR zimm is supported, and flush is handled.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; immediates are extended to XLEN.
- `DEPTH`, 2: result-queue entries, power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all queued entries and any same-cycle input.
- `in_valid`  in  1  `inst`/`pc` valid.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`, registered-state only.
- `inst`  in  32  instruction word.
- `pc`  in  XLEN  instruction address.
- `out_valid`  out  1  queue head valid (`count != 0`).
- `out_ready`  in  1  consumer takes head.
- `imm`  out  XLEN  immediate of the head entry.
- `imm_type`  out  3  format code of the head entry.
- `target`  out  XLEN  `pc + imm` of the head entry, mod 2^XLEN.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Push when `in_valid && in_ready && !flush`; pop when `out_valid && out_ready && !flush`.
- Classification by `inst[6:0]`:
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Z: 1110011 with `funct3[2]=1`.
  - NONE: everything else, including SYSTEM with `funct3[2]=0`.
- Codes: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7.
- Formation:
  - I: `inst[31:20]`, sign-extended.
  - S: `{inst[31:25],inst[11:7]}`, sign-extended.
  - B: `{inst[31],inst[7],inst[30:25],inst[11:8],0}`, sign-extended.
  - U: `{inst[31:12],12'b0}`, sign-extended from bit 31 when XLEN=64.
  - J: `{inst[31],inst[19:12],inst[20],inst[30:21],0}`, sign-extended.
  - Z: `inst[19:15]`, zero-extended.
  - NONE: 0.
- `target` is always computed. It is meaningful only for B, J and AUIPC; otherwise it is don't-care but deterministic.
- The queue is a circular buffer with read/write pointers wrapping mod DEPTH.
- Full: no push, `in_ready=0`.
- Empty: no pop, `out_valid=0`, outputs hold the last head value.
- Push and pop in the same cycle while neither empty nor full: count unchanged.
- Push and pop while full: not possible, because `in_ready=0`.
- Flush:
  - Pointers and count go to 0 next cycle.
  - A push requested in the same cycle is dropped.
  - The consumer must ignore the head in the flush cycle.
- Reset (`reset_n=0` at a clock edge), including mid-stream:
  - Pointers and count reset to 0; `in_ready=1`, `out_valid=0`.
  - `imm`, `imm_type` and `target` reset to 0.
  - Storage contents are not reset.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is visible on the outputs after edge N (`out_valid=1` in cycle N+1).
- No combinational path from `inst`/`pc` to any output.
- No combinational path from `out_ready` to `in_ready`.
- Sustained throughput is 1 entry/cycle when `out_ready=1`.
- `count` updates at every edge: +1 on push only, −1 on pop only, otherwise unchanged.
- Immediate formation and the adder sit before the queue write. The critical path is the decode mux plus an XLEN-bit adder.

## Structure
- Shared package `imm_gen_pkg` holds:
  - imm_type code constants (IMM_I … IMM_NONE);
  - opcode constants (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM).
- One combinational sub-module, `imm_form`: inputs `inst`, `pc`; outputs `imm_type`, `imm`, `target`; parameter XLEN.
- Queue control (pointers, count, flush) lives in `imm_gen_pipe`.

## Test plan
- Reset: hold `reset_n=0` 2 cycles → `in_ready=1`, `out_valid=0`, `count=0`, `imm=0`.
- I-type, XLEN=32: push `0xFFF00093` → next cycle `imm=0xFFFFFFFF`, `imm_type=0`.
- Branch: push `0xFE000EE3` with `pc=0x100` → `imm=0xFFFFFFFC`, `imm_type=2`, `target=0x000000FC`.
- CSR and U-type:
  - `0x300FD073` (csrrwi) → `imm=0x1F`, `imm_type=5`.
  - At XLEN=64, `0x800000B7` (lui) → `imm=0xFFFFFFFF80000000`, `imm_type=3`.
- Backpressure with DEPTH=2, `out_ready=0`:
  - push 3 valid instructions → 2 accepted, `in_ready=0`, `count=2`;
  - then set `out_ready=1` → entries drain in order, one per cycle.
- Flush: with `count=2`, assert `flush` together with `in_valid=1` → next cycle `count=0`, `out_valid=0`, and the input is not enqueued.
